// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron step scheduler.
//   DATA_W  : default potential/weight/threshold width
//   state_t : sweep sequencer states
//   decay() : leaky decay of a membrane potential
package snn_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Leak removes v >> shift from the potential. A shift of 0 removes
    // everything, so the neuron forgets its history completely.
    function automatic logic [DATA_W-1:0] decay(input logic [DATA_W-1:0] v,
                                                input logic [4:0]        shift);
        return v - (v >> shift);
    endfunction

endpackage

// File: rtl/neuron_potential_adder.sv
// Potential adder/comparator: adds the buffered synaptic weight to the
// decayed potential (wrapping) and compares the sum against the threshold.
//   weight_i            : accumulated weight for the neuron
//   decayed_potential_i : potential after leak
//   threshold_i         : unsigned firing threshold
//   potential_o         : wrapped sum
//   spike_o             : potential_o >= threshold_i
module neuron_potential_adder #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] weight_i,
    input  logic [DATA_W-1:0] decayed_potential_i,
    input  logic [DATA_W-1:0] threshold_i,
    output logic [DATA_W-1:0] potential_o,
    output logic              spike_o
);

    assign potential_o = weight_i + decayed_potential_i;
    assign spike_o     = (potential_o >= threshold_i);

endmodule

// File: rtl/neuron_state_bank.sv
// Per-neuron potential and accumulator storage.
//   rd_idx_i / rd_v_o / rd_acc_o        : combinational read for the sweep
//   wr_en_i / wr_idx_i / wr_v_i         : sweep write-back (also clears acc)
//   acc_en_i / acc_idx_i / acc_w_i      : event accumulate; ids >= N dropped
module neuron_state_bank #(
    parameter int N_NEURONS = 16,
    parameter int ID_W      = 4,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   rd_idx_i,
    output logic [DATA_W-1:0] rd_v_o,
    output logic [DATA_W-1:0] rd_acc_o,
    input  logic              wr_en_i,
    input  logic [ID_W-1:0]   wr_idx_i,
    input  logic [DATA_W-1:0] wr_v_i,
    input  logic              acc_en_i,
    input  logic [ID_W-1:0]   acc_idx_i,
    input  logic [DATA_W-1:0] acc_w_i
);

    logic [N_NEURONS-1:0][DATA_W-1:0] v_q;
    logic [N_NEURONS-1:0][DATA_W-1:0] acc_q;

    // Decoded mux so an index beyond the bank reads zero instead of X.
    always_comb begin
        rd_v_o   = '0;
        rd_acc_o = '0;
        for (int n = 0; n < N_NEURONS; n++) begin
            if (rd_idx_i == ID_W'(n)) begin
                rd_v_o   = v_q[n];
                rd_acc_o = acc_q[n];
            end
        end
    end

    // The scheduler never writes and accumulates in the same cycle
    // (accumulate only in IDLE, write only in UPDATE); write wins regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            acc_q <= '0;
        end else begin
            for (int n = 0; n < N_NEURONS; n++) begin
                if (wr_en_i && wr_idx_i == ID_W'(n)) begin
                    v_q[n]   <= wr_v_i;
                    acc_q[n] <= '0;
                end else if (acc_en_i && acc_idx_i == ID_W'(n)) begin
                    acc_q[n] <= acc_q[n] + acc_w_i;
                end
            end
        end
    end

endmodule

// File: rtl/neuron_step_scheduler.sv
// Timestep scheduler for a bank of leaky integrate-and-fire neurons.
// Buffers weighted events between steps, then on step_start sweeps every
// neuron (decay, add, threshold, reset on spike) and streams spike ids out.
//   v_threshold/v_reset/decay_shift : step parameters, latched at step_start
//   in_valid/in_ready/in_neuron_id/in_weight : synaptic event input
//   step_start/busy/step_done                : step control
//   spike_valid/spike_ready/spike_neuron_id  : spike output stream
// 2**ID_W must be >= N_NEURONS.
module neuron_step_scheduler #(
    parameter int N_NEURONS = 16,
    parameter int ID_W      = 4,
    parameter int DATA_W    = snn_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] v_threshold,
    input  logic [DATA_W-1:0] v_reset,
    input  logic [4:0]        decay_shift,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ID_W-1:0]   in_neuron_id,
    input  logic [DATA_W-1:0] in_weight,
    input  logic              step_start,
    output logic              busy,
    output logic              step_done,
    output logic              spike_valid,
    input  logic              spike_ready,
    output logic [ID_W-1:0]   spike_neuron_id
);

    import snn_pkg::*;

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_NEURONS - 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   idx_q, idx_d;
    logic [ID_W-1:0]   sid_q, sid_d;
    logic [DATA_W-1:0] thr_q, thr_d;
    logic [DATA_W-1:0] vres_q, vres_d;
    logic [4:0]        shift_q, shift_d;
    logic              in_ready_q;

    logic [DATA_W-1:0] rd_v, rd_acc, decayed, potential, wr_v;
    logic              spike, wr_en, acc_en;

    // in_ready is registered so it stays low while reset is held and only
    // rises on the first clock edge after release.
    assign acc_en = in_valid && in_ready_q;

    neuron_state_bank #(
        .N_NEURONS (N_NEURONS),
        .ID_W      (ID_W),
        .DATA_W    (DATA_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx_i  (idx_q),
        .rd_v_o    (rd_v),
        .rd_acc_o  (rd_acc),
        .wr_en_i   (wr_en),
        .wr_idx_i  (idx_q),
        .wr_v_i    (wr_v),
        .acc_en_i  (acc_en),
        .acc_idx_i (in_neuron_id),
        .acc_w_i   (in_weight)
    );

    assign decayed = decay(rd_v, shift_q);

    neuron_potential_adder #(
        .DATA_W (DATA_W)
    ) u_adder (
        .weight_i            (rd_acc),
        .decayed_potential_i (decayed),
        .threshold_i         (thr_q),
        .potential_o         (potential),
        .spike_o             (spike)
    );

    assign wr_v = spike ? vres_q : potential;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sid_d   = sid_q;
        thr_d   = thr_q;
        vres_d  = vres_q;
        shift_d = shift_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (step_start) begin
                    thr_d   = v_threshold;
                    vres_d  = v_reset;
                    shift_d = decay_shift;
                    idx_d   = '0;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                wr_en = 1'b1;
                if (spike) begin
                    sid_d   = idx_q;
                    state_d = ST_EMIT;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (spike_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_UPDATE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            sid_q      <= '0;
            thr_q      <= '0;
            vres_q     <= '0;
            shift_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sid_q      <= sid_d;
            thr_q      <= thr_d;
            vres_q     <= vres_d;
            shift_q    <= shift_d;
            in_ready_q <= (state_d == ST_IDLE);
        end
    end

    assign in_ready        = in_ready_q;
    assign busy            = (state_q != ST_IDLE);
    assign step_done       = (state_q == ST_DONE);
    assign spike_valid     = (state_q == ST_EMIT);
    assign spike_neuron_id = sid_q;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Bench for neuron_step_scheduler. The bank is sized at 12 neurons with a
// 4-bit id so ids 12..15 exercise the out-of-range discard path.
module tb_neuron_step_scheduler;

    localparam int N   = 12;
    localparam int IDW = 4;
    localparam int DW  = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  v_threshold = '0, v_reset = '0;
    logic [4:0]     decay_shift = '0;
    logic           in_valid = 1'b0, in_ready;
    logic [IDW-1:0] in_neuron_id = '0;
    logic [DW-1:0]  in_weight = '0;
    logic           step_start = 1'b0, busy, step_done;
    logic           spike_valid, spike_ready = 1'b1;
    logic [IDW-1:0] spike_neuron_id;

    always #5 clk = ~clk;

    neuron_step_scheduler #(.N_NEURONS(N), .ID_W(IDW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .v_threshold(v_threshold), .v_reset(v_reset),
        .decay_shift(decay_shift), .in_valid(in_valid), .in_ready(in_ready),
        .in_neuron_id(in_neuron_id), .in_weight(in_weight), .step_start(step_start),
        .busy(busy), .step_done(step_done), .spike_valid(spike_valid),
        .spike_ready(spike_ready), .spike_neuron_id(spike_neuron_id)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: neuron state as plain arrays, spikes as a queue.
    logic [DW-1:0] m_v[N];
    logic [DW-1:0] m_acc[N];
    int exp_spk[$];
    int obs_spk[$];

    // Observations of the last step.
    int cycles, dones;
    bit viol, unstable, idle_busy;

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_v[i] = '0;
            m_acc[i] = '0;
        end
    endtask

    task automatic model_event(input int id, input logic [DW-1:0] w);
        if (id < N) m_acc[id] = m_acc[id] + w;
    endtask

    task automatic model_step(input logic [DW-1:0] thr, input logic [DW-1:0] vres,
                              input int sh);
        longint unsigned div;
        logic [DW-1:0] d, p;
        exp_spk.delete();
        div = 64'd1 << sh;
        for (int i = 0; i < N; i++) begin
            d = m_v[i] - DW'(longint'(m_v[i]) / div);
            p = m_acc[i] + d;
            if (p >= thr) begin
                exp_spk.push_back(i);
                m_v[i] = vres;
            end else begin
                m_v[i] = p;
            end
            m_acc[i] = '0;
        end
    endtask

    function automatic string spk_str(input int q[$]);
        string s = "";
        foreach (q[k]) s = {s, $sformatf("%0d ", q[k])};
        return s;
    endfunction

    task automatic send_event(input int id, input logic [DW-1:0] w);
        @(negedge clk);
        in_valid = 1'b1;
        in_neuron_id = IDW'(id);
        in_weight = w;
        @(negedge clk);
        in_valid = 1'b0;
        model_event(id, w);
    endtask

    // Drives one step and records what the DUT did. An optional event is
    // presented in the same cycle as step_start. stall = cycles spike_ready
    // stays low on each spike before being accepted.
    task automatic run_step(input logic [DW-1:0] thr, input logic [DW-1:0] vres,
                            input int sh, input int stall, input bit extra_start,
                            input bit ev_en, input int ev_id, input logic [DW-1:0] ev_w);
        int sc;
        logic [IDW-1:0] held;
        sc = 0;
        held = '0;
        @(negedge clk);
        v_threshold = thr;
        v_reset = vres;
        decay_shift = 5'(sh);
        step_start = 1'b1;
        in_valid = ev_en;
        in_neuron_id = IDW'(ev_id);
        in_weight = ev_w;
        spike_ready = (stall == 0);
        if (ev_en) model_event(ev_id, ev_w);
        model_step(thr, vres, sh);
        // Scramble the step parameters so only the latched copies matter.
        @(negedge clk);
        step_start = 1'b0;
        in_valid = 1'b0;
        v_threshold = '1;
        v_reset = 32'hDEAD_BEEF;
        decay_shift = 5'd31;
        obs_spk.delete();
        cycles = 0;
        dones = 0;
        viol = 1'b0;
        unstable = 1'b0;
        idle_busy = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            step_start = (c == 3) && extra_start;
            if (busy !== 1'b1 || in_ready !== 1'b0) viol = 1'b1;
            if (spike_valid === 1'b1) begin
                if (sc == 0) held = spike_neuron_id;
                else if (spike_neuron_id !== held) unstable = 1'b1;
                if (sc < stall) begin
                    spike_ready = 1'b0;
                    sc++;
                end else begin
                    spike_ready = 1'b1;
                    obs_spk.push_back(int'(spike_neuron_id));
                    sc = 0;
                end
            end else begin
                spike_ready = (stall == 0);
            end
            if (step_done === 1'b1) begin
                dones++;
                cycles = c;
                break;
            end
            @(negedge clk);
        end
        step_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (step_done === 1'b1) dones++;
            if (busy !== 1'b0) idle_busy = 1'b1;
        end
        spike_ready = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, busy, step_done, spike_valid, spike_neuron_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b sv=%b id=%0d, need all 0",
                     in_ready, busy, step_done, spike_valid, spike_neuron_id);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_before_edge: got %b, need 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_after_release: got %b, need 1", in_ready);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dut.u_bank.v_q[i] !== '0 || dut.u_bank.acc_q[i] !== '0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got v=%h acc=%h, need 0", i,
                         dut.u_bank.v_q[i], dut.u_bank.acc_q[i]);
            end
        end
        model_clear();
    endtask

    task automatic test_no_events();
        run_step(100, 0, 1, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (dones !== 1 || cycles !== N + 1) begin
            errors++;
            $display("FAIL idle_step_timing: got dones=%0d cycles=%0d, need 1 and %0d",
                     dones, cycles, N + 1);
        end
        checks++;
        if (obs_spk.size() !== 0) begin
            errors++;
            $display("FAIL idle_step_spikes: got '%s', need none", spk_str(obs_spk));
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dut.u_bank.v_q[i] !== '0) begin
                errors++;
                $display("FAIL idle_step_v[%0d]: got %h, need 0", i, dut.u_bank.v_q[i]);
            end
        end
    endtask

    task automatic test_single_spike();
        send_event(3, 60);
        send_event(3, 50);
        run_step(100, 0, 1, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (spk_str(obs_spk) != "3 " || cycles !== N + 2) begin
            errors++;
            $display("FAIL single_spike: got '%s' in %0d cycles, need '3 ' in %0d",
                     spk_str(obs_spk), cycles, N + 2);
        end
        run_step(100, 0, 1, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (obs_spk.size() !== 0 || dut.u_bank.v_q[3] !== '0) begin
            errors++;
            $display("FAIL single_spike_after: got '%s' v3=%0d, need none and 0",
                     spk_str(obs_spk), dut.u_bank.v_q[3]);
        end
    endtask

    task automatic test_decay();
        send_event(5, 80);
        run_step(100, 9, 2, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (obs_spk.size() !== 0 || dut.u_bank.v_q[5] !== 80) begin
            errors++;
            $display("FAIL decay_first: got '%s' v5=%0d, need none and 80",
                     spk_str(obs_spk), dut.u_bank.v_q[5]);
        end
        send_event(5, 40);
        run_step(100, 9, 2, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (spk_str(obs_spk) != "5 " || dut.u_bank.v_q[5] !== 9) begin
            errors++;
            $display("FAIL decay_threshold_equal: got '%s' v5=%0d, need '5 ' and 9",
                     spk_str(obs_spk), dut.u_bank.v_q[5]);
        end
        // Event in the same cycle as step_start belongs to that step.
        run_step(100, 0, 0, 0, 1'b0, 1'b1, 6, 200);
        checks++;
        if (spk_str(obs_spk) != "6 " || dut.u_bank.v_q[5] !== 0) begin
            errors++;
            $display("FAIL same_cycle_event: got '%s' v5=%0d, need '6 ' and 0",
                     spk_str(obs_spk), dut.u_bank.v_q[5]);
        end
    endtask

    task automatic test_backpressure();
        send_event(7, 150);
        send_event(1, 150);
        send_event(2, 150);
        run_step(100, 0, 0, 5, 1'b0, 1'b0, 0, 0);
        checks++;
        if (spk_str(obs_spk) != "1 2 7 ") begin
            errors++;
            $display("FAIL bp_order: got '%s', need '1 2 7 '", spk_str(obs_spk));
        end
        checks++;
        if (cycles !== N + 3 * 6 + 1 || dones !== 1) begin
            errors++;
            $display("FAIL bp_timing: got cycles=%0d dones=%0d, need %0d and 1",
                     cycles, dones, N + 19);
        end
        checks++;
        if (viol || unstable || idle_busy) begin
            errors++;
            $display("FAIL bp_hold: got viol=%0b unstable=%0b idle_busy=%0b, need 0 0 0",
                     viol, unstable, idle_busy);
        end
    endtask

    task automatic test_ignore_and_wrap();
        @(negedge clk);
        in_valid = 1'b1;
        in_neuron_id = IDW'(N);
        in_weight = 32'd1000;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL oob_ready: got %b, need 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        send_event(4, 32'hFFFF_FFF0);
        send_event(4, 32'hFFFF_FFF0);
        checks++;
        if (dut.u_bank.acc_q[4] !== 32'hFFFF_FFE0) begin
            errors++;
            $display("FAIL acc_wrap: got %h, need ffffffe0", dut.u_bank.acc_q[4]);
        end
        run_step(32'hFFFF_FFF0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
        checks++;
        if (dones !== 1 || cycles !== N + 1 || obs_spk.size() !== 0) begin
            errors++;
            $display("FAIL ignored_start: got dones=%0d cycles=%0d spikes='%s', need 1 %0d none",
                     dones, cycles, spk_str(obs_spk), N + 1);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dut.u_bank.v_q[i] !== m_v[i]) begin
                errors++;
                $display("FAIL wrap_v[%0d]: got %h, need %h", i, dut.u_bank.v_q[i], m_v[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 8; s++) begin
            int nev, st, sh;
            logic [DW-1:0] thr, vres;
            nev = $urandom_range(0, 10);
            for (int e = 0; e < nev; e++)
                send_event($urandom_range(0, 15), DW'($urandom_range(0, 300)));
            thr  = DW'($urandom_range(50, 400));
            vres = DW'($urandom_range(0, 60));
            sh   = $urandom_range(0, 4);
            st   = $urandom_range(0, 2);
            run_step(thr, vres, sh, st, 1'b0, 1'b0, 0, 0);
            checks++;
            if (spk_str(obs_spk) != spk_str(exp_spk)) begin
                errors++;
                $display("FAIL rand%0d_spikes: got '%s', need '%s'", s,
                         spk_str(obs_spk), spk_str(exp_spk));
            end
            checks++;
            if (cycles !== N + exp_spk.size() * (st + 1) + 1 || dones !== 1 || viol || unstable) begin
                errors++;
                $display("FAIL rand%0d_timing: got cycles=%0d dones=%0d viol=%0b unst=%0b, need %0d 1 0 0",
                         s, cycles, dones, viol, unstable, N + exp_spk.size() * (st + 1) + 1);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (dut.u_bank.v_q[i] !== m_v[i]) begin
                    errors++;
                    $display("FAIL rand%0d_v[%0d]: got %0d, need %0d", s, i,
                             dut.u_bank.v_q[i], m_v[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        bit seen;
        seen = 1'b0;
        send_event(2, 500);
        send_event(9, 20);
        @(negedge clk);
        v_threshold = 100;
        v_reset = 0;
        decay_shift = 5'd1;
        step_start = 1'b1;
        spike_ready = 1'b0;
        @(negedge clk);
        step_start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (spike_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_reset_reach_emit: got no spike_valid in 50 cycles, need one");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (spike_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got sv=%b busy=%b rdy=%b, need 0 0 0",
                     spike_valid, busy, in_ready);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dut.u_bank.v_q[i] !== '0 || dut.u_bank.acc_q[i] !== '0) begin
                errors++;
                $display("FAIL mid_reset_state[%0d]: got v=%h acc=%h, need 0", i,
                         dut.u_bank.v_q[i], dut.u_bank.acc_q[i]);
            end
        end
        model_clear();
        spike_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_release: got rdy=%b busy=%b, need 1 0", in_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_no_events();
        test_single_spike();
        test_decay();
        test_backpressure();
        test_ignore_and_wrap();
        test_random();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
